scc_prefetch_fetch: RTL

//  Parametrised instruction-fetch unit for the SCC core, with a prefetch queue.

---
 rtl/scc_pkg.sv | 14 +
 rtl/scc_sync_fifo.sv | 53 +++++
 rtl/scc_prefetch_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/scc_pkg.sv
// Shared SCC core constants and payload types.
package scc_pkg;

  localparam int unsigned SCC_ADDR_W  = 32;
  localparam int unsigned SCC_INSTR_W = 32;
  localparam int unsigned SCC_PC_STEP = 4;
  localparam logic [SCC_ADDR_W-1:0] SCC_RESET_PC = '0;

  typedef struct packed {
    logic [SCC_INSTR_W-1:0] instr;
    logic [SCC_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/scc_sync_fifo.sv
// Synchronous FIFO with flush; wrap-bit pointers give full/empty without a separate counter.
module scc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[IDX_W-1:0]];
  // A full queue may take a push only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[IDX_W-1:0]] <= din;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/scc_prefetch_fetch.sv
// SCC instruction fetch: sequential PC issue, in-order response capture into a prefetch queue,
// branch redirect with stale-response discard, and halt.
module scc_prefetch_fetch
  import scc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = SCC_ADDR_W,
  parameter int unsigned       INSTR_W  = SCC_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(SCC_RESET_PC),
  parameter int unsigned       PC_STEP  = SCC_PC_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          in_mem_addr,
  output logic                       in_mem_en,
  input  logic                       in_mem_ready,
  input  logic [INSTR_W-1:0]         in_mem,
  input  logic                       in_mem_valid,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic [INSTR_W-1:0]         instruction,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       fetch_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_next;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W:0]    occupancy;
  logic              accept;
  logic              ret;
  logic              drop;
  logic              q_push;
  logic              q_pop;
  logic              q_empty;
  entry_t            q_din;
  entry_t            q_dout;

  // Every outstanding request already owns a queue slot, so responses can never overflow.
  assign occupancy   = {1'b0, inflight} + {1'b0, level};
  assign in_mem_en   = reset && !halt && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign in_mem_addr = fetch_pc;

  assign accept        = in_mem_en && in_mem_ready;
  assign ret           = in_mem_valid && (inflight != '0);
  assign drop          = ret && (discard != '0);
  assign inflight_next = inflight + CNT_W'(accept) - CNT_W'(ret);

  assign q_push = ret && !drop && !redirect;
  assign q_pop  = instr_valid && instr_ready && !redirect;
  assign q_din  = '{instr: in_mem, pc: resp_pc};

  assign instruction = q_dout.instr;
  assign instr_pc    = q_dout.pc;
  assign instr_valid = !q_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      inflight  <= '0;
      discard   <= '0;
      fetch_err <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (in_mem_valid && (inflight == '0)) fetch_err <= 1'b1;
      // Requests still unreturned after a redirect carry stale data and must be dropped.
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= inflight_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (q_push) resp_pc  <= resp_pc + ADDR_W'(PC_STEP);
        if (drop)   discard  <= discard - CNT_W'(1);
      end
    end
  end

  scc_sync_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .count (level),
    .empty (q_empty)
  );

endmodule
